// File: rtl/fluid_board_soc_nios2_qsys_0_oci_dct_capture_if.sv
// Stream bundle for the DCT capture block: the frame capture side and the drained head-frame side.
interface fluid_board_soc_nios2_qsys_0_oci_dct_capture_if #(
  parameter int SLOT_W = 10,
  parameter int SLOTS  = 3,
  parameter int CNT_W  = 4
);
  logic [SLOT_W*SLOTS-1:0] dct_buffer;
  logic [CNT_W-1:0]        dct_count;
  logic                    dct_valid;
  logic [SLOT_W*SLOTS-1:0] out_data;
  logic [CNT_W-1:0]        out_count;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output dct_buffer, dct_count, dct_valid, out_ready,
    input  out_data, out_count, out_valid
  );

  modport slave (
    input  dct_buffer, dct_count, dct_valid, out_ready,
    output out_data, out_count, out_valid
  );
endinterface

// File: rtl/fluid_board_soc_nios2_qsys_0_oci_dct_capture.sv
// Captures DCT trace frames into a first-word-fall-through FIFO and drains them to a sink,
// with an ARMED -> FLUSH -> DONE end-of-test sequence and a saturating drop counter.
module fluid_board_soc_nios2_qsys_0_oci_dct_capture #(
  parameter int SLOT_W = 10,
  parameter int SLOTS  = 3,
  parameter int CNT_W  = 4,
  parameter int DEPTH  = 8,
  parameter int DROP_W = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  fluid_board_soc_nios2_qsys_0_oci_dct_capture_if.slave dct,
  input  logic                       test_ending,
  input  logic                       test_has_ended,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic [DROP_W-1:0]          drop_count,
  output logic                       overflow,
  output logic                       flushing,
  output logic                       done
);

  localparam int FRAME_W = SLOT_W * SLOTS;
  localparam int AW      = $clog2(DEPTH);
  localparam int LW      = AW + 1;
  localparam logic [LW-1:0]     PTR_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [LW-1:0]     LVL_ZERO = {LW{1'b0}};
  localparam logic [LW-1:0]     LVL_FULL = LW'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(SLOTS);
  localparam logic [DROP_W-1:0] DROP_ONE = {{(DROP_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_ARMED = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [LW-1:0]      wr_cnt_q, wr_cnt_d;
  logic [LW-1:0]      rd_cnt_q, rd_cnt_d;
  logic [DROP_W-1:0]  drop_q, drop_d;
  logic               ovf_q, ovf_d;
  logic [FRAME_W-1:0] data_mem_q [DEPTH];
  logic [CNT_W-1:0]   cnt_mem_q  [DEPTH];

  logic [LW-1:0]      level_s;
  logic               full_s;
  logic               strobe_s;
  logic               push_s;
  logic               pop_s;
  logic               drop_ev_s;
  logic [CNT_W-1:0]   clamp_cnt_s;
  logic               head_valid_s;
  logic               flushing_s;
  logic               done_s;

  function automatic logic [DROP_W-1:0] sat_add(input logic [DROP_W-1:0] a,
                                                input logic [DROP_W-1:0] b);
    logic [DROP_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum[DROP_W]) begin
      sat_add = {DROP_W{1'b1}};
    end else begin
      sat_add = sum[DROP_W-1:0];
    end
  endfunction

  // Occupancy, handshake qualification and slot-count clamping.
  always_comb begin
    level_s      = wr_cnt_q - rd_cnt_q;
    full_s       = (level_s == LVL_FULL);
    head_valid_s = (level_s != LVL_ZERO) && (state_q != ST_DONE);
    strobe_s     = dct.dct_valid && (dct.dct_count != {CNT_W{1'b0}});
    pop_s        = !test_has_ended && head_valid_s && dct.out_ready;
    // a pop in the same cycle frees the slot a full-FIFO push needs
    push_s       = !test_has_ended && strobe_s && (state_q == ST_ARMED) && (!full_s || pop_s);
    drop_ev_s    = !test_has_ended && strobe_s && !push_s;
    if (dct.dct_count > CNT_MAX) begin
      clamp_cnt_s = CNT_MAX;
    end else begin
      clamp_cnt_s = dct.dct_count;
    end
  end

  // Pointer, drop counter and overflow next-state; abort clears the FIFO and charges its contents as drops.
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    drop_d   = drop_q;
    ovf_d    = ovf_q;
    if (test_has_ended) begin
      wr_cnt_d = LVL_ZERO;
      rd_cnt_d = LVL_ZERO;
      drop_d   = sat_add(drop_q, DROP_W'(level_s));
      if (level_s != LVL_ZERO) begin
        ovf_d = 1'b1;
      end else begin
        ovf_d = ovf_q;
      end
    end else begin
      if (push_s) begin
        wr_cnt_d = wr_cnt_q + PTR_ONE;
      end else begin
        wr_cnt_d = wr_cnt_q;
      end
      if (pop_s) begin
        rd_cnt_d = rd_cnt_q + PTR_ONE;
      end else begin
        rd_cnt_d = rd_cnt_q;
      end
      if (drop_ev_s) begin
        drop_d = sat_add(drop_q, DROP_ONE);
        ovf_d  = 1'b1;
      end else begin
        drop_d = drop_q;
        ovf_d  = ovf_q;
      end
    end
  end

  // FSM next-state.
  always_comb begin
    state_d = state_q;
    if (test_has_ended) begin
      state_d = ST_DONE;
    end else begin
      case (state_q)
        ST_ARMED: begin
          if (test_ending) begin
            state_d = ST_FLUSH;
          end else begin
            state_d = ST_ARMED;
          end
        end
        ST_FLUSH: begin
          if (level_s == LVL_ZERO) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_FLUSH;
          end
        end
        ST_DONE:  state_d = ST_DONE;
        default:  state_d = ST_DONE;
      endcase
    end
  end

  // FSM output decode.
  always_comb begin
    flushing_s = 1'b0;
    done_s     = 1'b0;
    case (state_q)
      ST_ARMED: begin
        flushing_s = 1'b0;
        done_s     = 1'b0;
      end
      ST_FLUSH: flushing_s = 1'b1;
      ST_DONE:  done_s     = 1'b1;
      default:  done_s     = 1'b1;
    endcase
  end

  // State and control registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_ARMED;
      wr_cnt_q <= LVL_ZERO;
      rd_cnt_q <= LVL_ZERO;
      drop_q   <= {DROP_W{1'b0}};
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      drop_q   <= drop_d;
      ovf_q    <= ovf_d;
    end
  end

  // Frame storage; contents are only observable through a valid head, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      data_mem_q[wr_cnt_q[AW-1:0]] <= dct.dct_buffer;
      cnt_mem_q[wr_cnt_q[AW-1:0]]  <= clamp_cnt_s;
    end
  end

  assign dct.out_valid = head_valid_s;
  assign dct.out_data  = head_valid_s ? data_mem_q[rd_cnt_q[AW-1:0]] : {FRAME_W{1'b0}};
  assign dct.out_count = head_valid_s ? cnt_mem_q[rd_cnt_q[AW-1:0]]  : {CNT_W{1'b0}};
  assign fifo_level    = level_s;
  assign drop_count    = drop_q;
  assign overflow      = ovf_q;
  assign flushing      = flushing_s;
  assign done          = done_s;

endmodule
